// File: rtl/out_mon_pkg.sv
// -----------------------------------------------------------------------------
// out_mon_pkg
//   Shared types and limits for the OUT window monitor.
//   - state_t    : FSM state encoding (IDLE, RUN, HOLD), 2 bits
//   - WINDOW_MAX : largest legal WINDOW value
// -----------------------------------------------------------------------------
package out_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int WINDOW_MAX = 255;

endpackage

// File: rtl/rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
//   Holds the previously sampled bit and flags a 0->1 transition on the
//   sample being taken this cycle.
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (prev -> 0)
//   clear  in   synchronous clear of prev
//   en     in   a sample is taken this cycle
//   d      in   sampled bit
//   rise   out  combinational: en & d & ~prev
// -----------------------------------------------------------------------------
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  input  logic d,
  output logic rise
);

  logic prev;

  // prev resets to 0, so a 1 on the very first sample counts as a rise.
  assign rise = en & d & ~prev;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the clock edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else if (clear) begin
      prev <= 1'b0;
    end else if (en) begin
      prev <= d;
    end
  end

endmodule

// File: rtl/out_window_monitor.sv
// -----------------------------------------------------------------------------
// out_window_monitor
//   Samples the single-bit OUT of the upstream combinational block on each
//   sample_en strobe over a window of WINDOW samples, then presents the number
//   of 1s and the number of 0->1 transitions on a valid/ready result port.
// Parameters
//   WINDOW  samples per window, legal range 2..WINDOW_MAX
//   CNT_W   derived counter width, $clog2(WINDOW+1)
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        begins a window (honoured only in IDLE)
//   abort        drops the current window, back to IDLE (highest priority)
//   sample_en    sample strobe for out_in
//   out_in       OUT of the upstream block
//   busy         1 while collecting (RUN)
//   res_valid    result valid (HOLD)
//   res_ready    consumer accepts the result
//   ones_cnt     sampled 1s in the window
//   rise_cnt     0->1 transitions in the window
//   overrun      sticky: a strobe arrived while the result was held
// -----------------------------------------------------------------------------
module out_window_monitor
  import out_mon_pkg::*;
#(
  parameter  int WINDOW = 16,
  localparam int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             sample_en,
  input  logic             out_in,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] rise_cnt,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] idx;
  logic             take;
  logic             last_sample;
  logic             start_ok;
  logic             clear;
  logic             rise;

  // abort outranks everything, so it masks every other action this cycle.
  assign take        = (state == RUN) && sample_en && !abort;
  assign last_sample = take && (idx == LAST_IDX);
  assign start_ok    = (state == IDLE) && start && !abort;
  assign clear       = abort || start_ok;

  assign busy      = (state == RUN);
  assign res_valid = (state == HOLD);

  rise_detect u_rise_detect (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .en    (take),
    .d     (out_in),
    .rise  (rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // NOTE: state_nx gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start)       state_nx = RUN;
        RUN:     if (last_sample) state_nx = HOLD;
        // start in the accepting cycle is deliberately ignored: IDLE only.
        HOLD:    if (res_ready)   state_nx = IDLE;
        default:                  state_nx = IDLE;
      endcase
    end
  end

  // Counts cannot wrap: at most WINDOW increments and WINDOW < 2**CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_cnt <= '0;
      rise_cnt <= '0;
      idx      <= '0;
    end else if (clear) begin
      ones_cnt <= '0;
      rise_cnt <= '0;
      idx      <= '0;
    end else if (take) begin
      ones_cnt <= ones_cnt + CNT_W'(out_in);
      rise_cnt <= rise_cnt + CNT_W'(rise);
      idx      <= idx + 1'b1;
    end
  end

  // Sticky until the next accepted start; abort leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (start_ok) begin
      overrun <= 1'b0;
    end else if ((state == HOLD) && sample_en && !abort) begin
      overrun <= 1'b1;
    end
  end

endmodule
